// File: rtl/serial_adder_seq.sv
// Bit-serial adder: {Cout,Sum} = A + B + Cin, one bit per clock, LSB first, with a start/busy/done handshake.
// Optional signed-overflow flag Ovf is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry, sum} of two bits.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Full adder built from two half-adder stages; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(a, b);
        h1 = half_add(h0[0], c);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] opa_r, opa_s;
    logic [WIDTH-1:0] opb_r, opb_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic             carry_r, carry_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             cout_r, cout_s;
    logic [1:0]       fa_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_r, ovf_s;
`endif

    // One full-adder step on the current LSBs and the carry flop.
    always_comb begin
        fa_s = full_add(opa_r[0], opb_r[0], carry_r);
    end

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_s = state_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        res_s   = res_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        cout_s  = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_s   = ovf_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    opa_s   = A;
                    opb_s   = B;
                    carry_s = Cin;
                    cnt_s   = CNT_ZERO;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                opa_s   = {1'b0, opa_r[WIDTH-1:1]};
                opb_s   = {1'b0, opb_r[WIDTH-1:1]};
                res_s   = {fa_s[0], res_r[WIDTH-1:1]};
                carry_s = fa_s[1];
                if (cnt_r == CNT_LAST) begin
                    // Last bit: the operand LSBs now hold the original MSBs.
                    cnt_s   = CNT_ZERO;
                    sum_s   = {fa_s[0], res_r[WIDTH-1:1]};
                    cout_s  = fa_s[1];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_s   = (opa_r[0] == opb_r[0]) && (fa_s[0] != opa_r[0]);
`endif
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    opa_s   = A;
                    opb_s   = B;
                    carry_s = Cin;
                    cnt_s   = CNT_ZERO;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == RUN);
        done_s = (state_s == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            res_r   <= res_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= ovf_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Sum  = sum_r;
    assign Cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf  = ovf_r;
`endif

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial, multi-cycle successor to the single-bit half adder. It adds two WIDTH-bit unsigned operands plus a carry-in, one bit per clock, LSB first. A single registered carry flop and a one-bit full-adder cell (two half-adder stages) do all the arithmetic. The block is the area-minimal adder datapath for wide operands, with a start/busy/done handshake toward the controlling logic.

## Interface
Parameters:
- WIDTH, default 8: operand and Sum width in bits; legal range 2..64.

Ports:
- clk, input, 1: rising-edge clock; the block's only clock.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- start, input, 1: request; sampled only when the block is idle or in the done cycle.
- A, input, WIDTH: operand A; captured on the accepted start edge.
- B, input, WIDTH: operand B; captured on the accepted start edge.
- Cin, input, 1: carry-in; captured on the accepted start edge.
- busy, output, 1: high while the add is in progress.
- done, output, 1: single-cycle pulse marking a valid result.
- Sum, output, WIDTH: registered result; held until the next completion.
- Cout, output, 1: registered carry-out; held with Sum.
- Ovf, output, 1: signed overflow flag; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 → load internal shift registers opA=A, opB=B and the carry flop with Cin; clear the bit counter; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - s = opA[0]^opB[0]^c; c' = (opA[0]&opB[0]) | (c&(opA[0]^opB[0])).
  - opA and opB shift right by one.
  - s shifts into the MSB of the internal result register.
  - The counter increments.
  - After the WIDTH-th bit, copy the result register to Sum and c' to Cout; go to DONE.
- DONE, one cycle:
  - done=1.
  - start=1 → accept new operands exactly as in IDLE; go to RUN.
  - start=0 → go to IDLE.
- start while in RUN is ignored; it is not queued, and A, B and Cin are not re-sampled.
- Sum and Cout do not change during RUN; they keep the previous result until the final edge of the next operation.
- Arithmetic: {Cout,Sum} = A + B + Cin, exact, modulo 2^(WIDTH+1). The bit counter is $clog2(WIDTH) bits wide and wraps to 0 on completion.

## Timing
- Reset values: busy=0, done=0, Sum=0, Cout=0, Ovf=0. Internal opA, opB, carry and counter are all 0.
- Latency:
  - Accepting edge E0 → busy=1 from E0.
  - Bits are computed on edges E1..E_WIDTH.
  - From E_WIDTH: done=1, busy=0, and Sum/Cout are valid, all for one cycle.
  - Total: WIDTH cycles from the accepting edge to the done cycle.
- Throughput: back-to-back operation with start held high gives one result every WIDTH+1 cycles, because the DONE cycle is also the next accepting cycle.
- busy and done are never high together.
- rst mid-operation: the FSM returns to IDLE on the same edge and all outputs take their reset values. A start that is high on the reset edge is ignored.
- Operands may change freely after the accepting edge.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Ovf port exists and is registered with Sum.
  - Ovf = (A[WIDTH-1]==B[WIDTH-1]) && (Sum[WIDTH-1]!=A[WIDTH-1]), computed from the captured operand MSBs and the final sum bit.
  - Ovf updates only on the completion edge; reset value 0.
- SERIAL_ADDER_OVF_EN undefined:
  - Ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, one start pulse → done exactly 8 cycles after the accepting edge; Sum=0x96, Cout=0; busy high for 8 cycles.
- A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1. A=0xFF, B=0x00, Cin=1 → Sum=0x00, Cout=1.
- start held high with operand pairs (0x01,0x02) then (0x10,0x20) → results 0x03 then 0x30; done pulses 9 cycles apart; Sum holds 0x03 throughout the second RUN.
- start pulsed in cycle 3 of RUN with A=0xAA → ignored; first result unchanged; no extra done pulse.
- rst asserted in cycle 4 of RUN → on the next edge busy=0, done=0, Sum=0, Cout=0, state IDLE; a subsequent add of 0x12+0x34 yields 0x46.
- With SERIAL_ADDER_OVF_EN:
  - 0x7F+0x01 → Ovf=1, Sum=0x80.
  - 0x80+0x80 → Ovf=1, Cout=1, Sum=0x00.
  - 0x05+0x03 → Ovf=0.
